// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: synchronises and debounces the start push-button and the
// slide-switch word, producing clean levels plus one-cycle change strobes for the Nios PIOs.
module panel_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHAVE_W         = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               key_start_n_i,
    input  logic [CHAVE_W-1:0] sw_chave_i,
    output logic               start_o,
    output logic               start_pulse_o,
    output logic [CHAVE_W-1:0] chave_o,
    output logic               chave_changed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    logic               key_meta_q, key_meta_d;
    logic               key_sync_q, key_sync_d;
    logic [CHAVE_W-1:0] chave_meta_q, chave_meta_d;
    logic [CHAVE_W-1:0] chave_sync_q, chave_sync_d;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               start_pulse_q, start_pulse_d;

    logic [CHAVE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   ccnt_q, ccnt_d;
    logic [CHAVE_W-1:0] chave_q, chave_d;
    logic               chave_changed_q, chave_changed_d;

    logic               pressed_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [CNT_W-1:0]   ccnt_inc_s;

    // Two-stage synchronisers; each stage simply follows the previous one.
    always_comb begin
        key_meta_d   = key_start_n_i;
        key_sync_d   = key_meta_q;
        chave_meta_d = sw_chave_i;
        chave_sync_d = chave_meta_q;
    end

    always_comb begin
        pressed_s  = ~key_sync_q;
        cnt_inc_s  = (cnt_q  == CNT_MAX) ? cnt_q  : (cnt_q  + CNT_ONE);
        ccnt_inc_s = (ccnt_q == CNT_MAX) ? ccnt_q : (ccnt_q + CNT_ONE);
    end

    // Start button debounce FSM; any disagreement in a WAIT state falls back to the stable state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        start_d       = start_q;
        start_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d       = ST_PRESSED;
                    start_d       = 1'b1;
                    start_pulse_d = 1'b1;
                    cnt_d         = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    start_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                start_d = 1'b0;
            end
        endcase
    end

    // Switch word group debounce; the candidate tracks the output while idle so a new
    // value always starts counting from one.
    always_comb begin
        cand_d          = cand_q;
        ccnt_d          = ccnt_q;
        chave_d         = chave_q;
        chave_changed_d = 1'b0;
        if (chave_sync_q == chave_q) begin
            cand_d = chave_q;
            ccnt_d = CNT_ZERO;
        end else if (chave_sync_q != cand_q) begin
            cand_d = chave_sync_q;
            ccnt_d = CNT_ONE;
        end else if (ccnt_q == CNT_MAX) begin
            chave_d         = cand_q;
            chave_changed_d = 1'b1;
            ccnt_d          = CNT_ZERO;
        end else begin
            ccnt_d = ccnt_inc_s;
        end
    end

    // State registers; synchronisers clear to the inactive pin levels.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_meta_q      <= 1'b1;
            key_sync_q      <= 1'b1;
            chave_meta_q    <= {CHAVE_W{1'b0}};
            chave_sync_q    <= {CHAVE_W{1'b0}};
            state_q         <= ST_IDLE;
            cnt_q           <= CNT_ZERO;
            start_q         <= 1'b0;
            start_pulse_q   <= 1'b0;
            cand_q          <= {CHAVE_W{1'b0}};
            ccnt_q          <= CNT_ZERO;
            chave_q         <= {CHAVE_W{1'b0}};
            chave_changed_q <= 1'b0;
        end else begin
            key_meta_q      <= key_meta_d;
            key_sync_q      <= key_sync_d;
            chave_meta_q    <= chave_meta_d;
            chave_sync_q    <= chave_sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            start_q         <= start_d;
            start_pulse_q   <= start_pulse_d;
            cand_q          <= cand_d;
            ccnt_q          <= ccnt_d;
            chave_q         <= chave_d;
            chave_changed_q <= chave_changed_d;
        end
    end

    assign start_o         = start_q;
    assign start_pulse_o   = start_pulse_q;
    assign chave_o         = chave_q;
    assign chave_changed_o = chave_changed_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Self-checking bench for panel_input_conditioner: directed latency/bounce/reset scenarios
// and a randomized run against a run-length reference model of the debounce rules.
module tb_panel_input_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       key;
    logic [3:0] sw;
    logic       start;
    logic       pulse;
    logic [3:0] chave;
    logic       chg;

    int tests_run = 0;
    int failed    = 0;

    panel_input_conditioner #(.DEBOUNCE_CYCLES(D), .CHAVE_W(4)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .key_start_n_i   (key),
        .sw_chave_i      (sw),
        .start_o         (start),
        .start_pulse_o   (pulse),
        .chave_o         (chave),
        .chave_changed_o (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an input level is accepted once the synced value has differed
    // from the current output, with the same value, for D+1 consecutive clock edges.
    logic       m_k1, m_k2;
    logic [3:0] m_w1, m_w2, m_wprev;
    logic       m_start, m_pulse, m_chg;
    logic [3:0] m_chave;
    int         m_krun, m_wrun;

    function automatic int wrun_next(input logic [3:0] s, input logic [3:0] prev,
                                     input logic [3:0] cur, input int run);
        if (s == cur) return 0;
        if (s == prev) return run + 1;
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 <= 1'b1; m_k2 <= 1'b1; m_w1 <= 4'h0; m_w2 <= 4'h0; m_wprev <= 4'h0;
            m_start <= 1'b0; m_pulse <= 1'b0; m_chave <= 4'h0; m_chg <= 1'b0;
            m_krun <= 0; m_wrun <= 0;
        end else begin
            m_k1 <= key; m_k2 <= m_k1; m_w1 <= sw; m_w2 <= m_w1; m_wprev <= m_w2;
            m_pulse <= 1'b0;
            m_chg   <= 1'b0;
            if ((!m_k2) != m_start) begin
                if (m_krun + 1 > D) begin
                    m_start <= !m_k2; m_pulse <= !m_k2; m_krun <= 0;
                end else begin
                    m_krun <= m_krun + 1;
                end
            end else begin
                m_krun <= 0;
            end
            if (wrun_next(m_w2, m_wprev, m_chave, m_wrun) > D) begin
                m_chave <= m_w2; m_chg <= 1'b1; m_wrun <= 0;
            end else begin
                m_wrun <= wrun_next(m_w2, m_wprev, m_chave, m_wrun);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            key = 1'($urandom_range(0, 1));
            sw  = 4'($urandom_range(0, 15));
            tick();
            tests_run++;
            if ({start, pulse, chave, chg} !== 7'b0) begin
                failed++;
                $display("FAIL reset_hold i=%0d got %b exp 0000000", i, {start, pulse, chave, chg});
            end
        end
        key = 1'b1; sw = 4'h0; rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            tests_run++;
            if ({start, pulse, chave, chg} !== 7'b0) begin
                failed++;
                $display("FAIL reset_idle i=%0d got %b exp 0000000", i, {start, pulse, chave, chg});
            end
        end
    endtask

    task automatic test_clean_press();
        key = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (start !== (i >= 6) || pulse !== (i == 6)) begin
                failed++;
                $display("FAIL press edge=%0d got start=%b pulse=%b exp start=%b pulse=%b",
                         i, start, pulse, (i >= 6), (i == 6));
            end
        end
        key = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (start !== (i < 6) || pulse !== 1'b0) begin
                failed++;
                $display("FAIL release edge=%0d got start=%b pulse=%b exp start=%b pulse=0",
                         i, start, pulse, (i < 6));
            end
        end
    endtask

    task automatic test_bounce();
        int npulse = 0;
        for (int i = 0; i < 30; i++) begin
            key = (i == 3 || i == 6) ? 1'b1 : 1'b0;
            tick();
            npulse += int'(pulse);
            tests_run++;
            if (pulse !== (i == 13) || start !== (i >= 13)) begin
                failed++;
                $display("FAIL bounce edge=%0d got start=%b pulse=%b exp start=%b pulse=%b",
                         i, start, pulse, (i >= 13), (i == 13));
            end
        end
        tests_run++;
        if (npulse != 1) begin
            failed++;
            $display("FAIL bounce_count got %0d exp 1", npulse);
        end
        key = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_switches();
        sw = 4'hA;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (chave !== ((i >= 6) ? 4'hA : 4'h0) || chg !== (i == 6)) begin
                failed++;
                $display("FAIL switch edge=%0d got chave=%h chg=%b exp chave=%h chg=%b",
                         i, chave, chg, ((i >= 6) ? 4'hA : 4'h0), (i == 6));
            end
        end
        for (int i = 0; i < 20; i++) begin
            sw = (i < 2) ? 4'hB : 4'hA;
            tick();
            tests_run++;
            if (chave !== 4'hA || chg !== 1'b0) begin
                failed++;
                $display("FAIL glitch edge=%0d got chave=%h chg=%b exp chave=a chg=0", i, chave, chg);
            end
        end
    endtask

    task automatic test_reset_mid();
        key = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({start, pulse, chave, chg} !== 7'b0) begin
                failed++;
                $display("FAIL reset_mid i=%0d got %b exp 0000000", i, {start, pulse, chave, chg});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (start !== (i >= 6) || pulse !== (i == 6) ||
                chave !== ((i >= 6) ? 4'hA : 4'h0) || chg !== (i == 6)) begin
                failed++;
                $display("FAIL after_reset edge=%0d got start=%b pulse=%b chave=%h chg=%b exp %b %b %h %b",
                         i, start, pulse, chave, chg, (i >= 6), (i == 6), ((i >= 6) ? 4'hA : 4'h0), (i == 6));
            end
        end
    endtask

    task automatic test_long_hold_simultaneous();
        int npulse = 0;
        int nchg   = 0;
        key = 1'b1; sw = 4'h0;
        repeat (30) tick();
        key = 1'b0; sw = 4'h3;
        for (int i = 0; i < 1000; i++) begin
            tick();
            npulse += int'(pulse);
            nchg   += int'(chg);
            if (i == 6) begin
                tests_run++;
                if (pulse !== 1'b1 || chg !== 1'b1) begin
                    failed++;
                    $display("FAIL simultaneous got pulse=%b chg=%b exp 1 1", pulse, chg);
                end
            end
        end
        tests_run++;
        if (npulse != 1 || nchg != 1 || start !== 1'b1 || chave !== 4'h3) begin
            failed++;
            $display("FAIL long_hold got pulses=%0d strobes=%0d start=%b chave=%h exp 1 1 1 3",
                     npulse, nchg, start, chave);
        end
        key = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_random();
        int hold_k = 0;
        int hold_w = 0;
        for (int i = 0; i < 4000; i++) begin
            tests_run++;
            if ({start, pulse, chave, chg} !== {m_start, m_pulse, m_chave, m_chg}) begin
                failed++;
                $display("FAIL random cyc=%0d got %b %b %h %b exp %b %b %h %b", i,
                         start, pulse, chave, chg, m_start, m_pulse, m_chave, m_chg);
            end
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            if (hold_k == 0) begin
                key    = 1'($urandom_range(0, 1));
                hold_k = $urandom_range(1, 10);
            end
            if (hold_w == 0) begin
                if ($urandom_range(0, 1) == 0) sw = sw ^ (4'h1 << $urandom_range(0, 3));
                else sw = 4'($urandom_range(0, 15));
                hold_w = $urandom_range(1, 10);
            end
            hold_k--;
            hold_w--;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; key = 1'b1; sw = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_switches();
        test_reset_mid();
        test_long_hold_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
